// File: rtl/nv_nvdla_sdp_mrdma_ig_cdt_sched.sv
// nv_nvdla_sdp_mrdma_ig_cdt_sched
//   Ingress read scheduler for the SDP MRDMA. Each surface read command is split
//   into DMA read requests of at most MAX_BURST atoms. A request is issued only
//   when the egress latency FIFO has a free entry for every beat of that chunk.
//   Credits are reserved when a request is issued and returned one per latency
//   FIFO pop. Every issued request is paired with a size token (chunk-1) so that
//   egress beat counting stays aligned with the requests.
//
// Optional build macro:
//   NVDLA_SDP_MRDMA_4KB_SPLIT_EN  also clip each chunk so that no request crosses
//                                 a 4 KB address boundary.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst  clock, asynchronous active-high reset
//   cmd_*                            read command {size=atoms-1, addr}
//   dma_rd_req_*                     DMA read request {chunk-1, chunk_addr}
//   cmd2dat_spt_*                    egress size token (chunk-1)
//   dma_rd_cdt_lat_fifo_pop          one credit returned per cycle when high
//   cdt_avail                        current credit count (debug)
//   cdt_err                          sticky credit-overflow flag
//   sched_idle                       idle with every credit returned
module nv_nvdla_sdp_mrdma_ig_cdt_sched #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned ATOM_BYTES = 32,
   parameter int unsigned MAX_BURST  = 16,
   parameter int unsigned LAT_DEPTH  = 256,
   parameter int unsigned SIZE_W     = 13
) (
   input  logic                               nvdla_core_clk,
   input  logic                               nvdla_core_rst,
   input  logic                               cmd_pvld,
   output logic                               cmd_prdy,
   input  logic [ADDR_W+SIZE_W-1:0]           cmd_pd,
   output logic                               dma_rd_req_pvld,
   input  logic                               dma_rd_req_prdy,
   output logic [ADDR_W+SIZE_W-1:0]           dma_rd_req_pd,
   output logic                               cmd2dat_spt_pvld,
   input  logic                               cmd2dat_spt_prdy,
   output logic [SIZE_W-1:0]                  cmd2dat_spt_pd,
   input  logic                               dma_rd_cdt_lat_fifo_pop,
   output logic [$clog2(LAT_DEPTH+1)-1:0]     cdt_avail,
   output logic                               cdt_err,
   output logic                               sched_idle
);

   localparam int unsigned CDT_W = $clog2(LAT_DEPTH + 1);
   localparam int unsigned CW1   = CDT_W + 1;
   localparam int unsigned REM_W = SIZE_W + 1;
   localparam int unsigned CHK_W = 7;

   typedef enum logic [1:0] {StIdle, StCalc, StSend} state_e;

   state_e              state;
   logic [ADDR_W-1:0]   cur_addr;
   logic [REM_W-1:0]    remaining;
   logic [CHK_W-1:0]    chunk;
   logic [CDT_W-1:0]    credits;
   logic                req_done;
   logic                spt_done;

   logic [REM_W-1:0]    chunk_lim;
   logic [CHK_W-1:0]    chunk_calc;
   logic                grant;
   logic [CW1-1:0]      cdt_sum;
   logic                req_done_nxt;
   logic                spt_done_nxt;
`ifdef NVDLA_SDP_MRDMA_4KB_SPLIT_EN
   logic [REM_W-1:0]    page_atoms;
`endif

   // Chunk size for the next request, derived from the live datapath registers.
   always_comb begin
      chunk_lim = remaining;
      if (remaining > REM_W'(MAX_BURST)) begin
         chunk_lim = REM_W'(MAX_BURST);
      end
`ifdef NVDLA_SDP_MRDMA_4KB_SPLIT_EN
      // Atoms left before the next 4 KB boundary; at least 1 for aligned addresses.
      page_atoms = (REM_W'(4096) - REM_W'(cur_addr[11:0])) / REM_W'(ATOM_BYTES);
      if (page_atoms < chunk_lim) begin
         chunk_lim = page_atoms;
      end
`endif
   end

   assign chunk_calc = CHK_W'(chunk_lim);

   // Grant compares against the registered credit count; a same-cycle pop is
   // only netted into the update.
   assign grant = (state == StCalc) && (32'(credits) >= 32'(chunk_calc));

   always_comb begin
      cdt_sum = CW1'(credits) + CW1'(dma_rd_cdt_lat_fifo_pop);
      if (grant) begin
         cdt_sum = cdt_sum - CW1'(chunk_calc);
      end
   end

   assign req_done_nxt = req_done | (dma_rd_req_pvld & dma_rd_req_prdy);
   assign spt_done_nxt = spt_done | (cmd2dat_spt_pvld & cmd2dat_spt_prdy);

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state            <= StIdle;
         cur_addr         <= '0;
         remaining        <= '0;
         chunk            <= '0;
         credits          <= CDT_W'(LAT_DEPTH);
         cdt_err          <= 1'b0;
         req_done         <= 1'b0;
         spt_done         <= 1'b0;
         cmd_prdy         <= 1'b1;
         dma_rd_req_pvld  <= 1'b0;
         dma_rd_req_pd    <= '0;
         cmd2dat_spt_pvld <= 1'b0;
         cmd2dat_spt_pd   <= '0;
      end else begin
         // Credit accounting: reserve on grant, return on pop, saturate on overflow.
         if (cdt_sum > CW1'(LAT_DEPTH)) begin
            credits <= CDT_W'(LAT_DEPTH);
            cdt_err <= 1'b1;
         end else begin
            credits <= CDT_W'(cdt_sum);
         end

         unique case (state)
            StIdle: begin
               if (cmd_pvld) begin
                  cur_addr  <= cmd_pd[ADDR_W-1:0];
                  remaining <= REM_W'(cmd_pd[ADDR_W +: SIZE_W]) + REM_W'(1);
                  cmd_prdy  <= 1'b0;
                  state     <= StCalc;
               end
            end
            StCalc: begin
               chunk <= chunk_calc;
               if (grant) begin
                  dma_rd_req_pvld  <= 1'b1;
                  dma_rd_req_pd    <= {SIZE_W'(chunk_calc) - SIZE_W'(1), cur_addr};
                  cmd2dat_spt_pvld <= 1'b1;
                  cmd2dat_spt_pd   <= SIZE_W'(chunk_calc) - SIZE_W'(1);
                  req_done         <= 1'b0;
                  spt_done         <= 1'b0;
                  state            <= StSend;
               end
            end
            StSend: begin
               // Each side retires independently; pd stays stable until both are done.
               if (dma_rd_req_pvld && dma_rd_req_prdy) begin
                  dma_rd_req_pvld <= 1'b0;
               end
               if (cmd2dat_spt_pvld && cmd2dat_spt_prdy) begin
                  cmd2dat_spt_pvld <= 1'b0;
               end
               req_done <= req_done_nxt;
               spt_done <= spt_done_nxt;
               if (req_done_nxt && spt_done_nxt) begin
                  req_done  <= 1'b0;
                  spt_done  <= 1'b0;
                  cur_addr  <= cur_addr + ADDR_W'(chunk) * ADDR_W'(ATOM_BYTES);
                  remaining <= remaining - REM_W'(chunk);
                  if (remaining == REM_W'(chunk)) begin
                     cmd_prdy <= 1'b1;
                     state    <= StIdle;
                  end else begin
                     state    <= StCalc;
                  end
               end
            end
            default: begin
               cmd_prdy <= 1'b1;
               state    <= StIdle;
            end
         endcase
      end
   end

   assign cdt_avail  = credits;
   assign sched_idle = (state == StIdle) && (credits == CDT_W'(LAT_DEPTH));

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_ig_cdt_sched.sv
module tb_nv_nvdla_sdp_mrdma_ig_cdt_sched;

   localparam int AW = 64;
   localparam int SW = 13;
   localparam int PW = AW + SW;

   logic          nvdla_core_clk = 1'b0;
   logic          nvdla_core_rst;
   logic          cmd_pvld;
   logic          cmd_prdy;
   logic [PW-1:0] cmd_pd;
   logic          dma_rd_req_pvld;
   logic          dma_rd_req_prdy;
   logic [PW-1:0] dma_rd_req_pd;
   logic          cmd2dat_spt_pvld;
   logic          cmd2dat_spt_prdy;
   logic [SW-1:0] cmd2dat_spt_pd;
   logic          dma_rd_cdt_lat_fifo_pop;
   logic [8:0]    cdt_avail;
   logic          cdt_err;
   logic          sched_idle;

   int n_chk  = 0;
   int n_pass = 0;

   logic [PW-1:0] req_log[$];
   logic [SW-1:0] spt_log[$];

   nv_nvdla_sdp_mrdma_ig_cdt_sched dut (
      .nvdla_core_clk          (nvdla_core_clk),
      .nvdla_core_rst          (nvdla_core_rst),
      .cmd_pvld                (cmd_pvld),
      .cmd_prdy                (cmd_prdy),
      .cmd_pd                  (cmd_pd),
      .dma_rd_req_pvld         (dma_rd_req_pvld),
      .dma_rd_req_prdy         (dma_rd_req_prdy),
      .dma_rd_req_pd           (dma_rd_req_pd),
      .cmd2dat_spt_pvld        (cmd2dat_spt_pvld),
      .cmd2dat_spt_prdy        (cmd2dat_spt_prdy),
      .cmd2dat_spt_pd          (cmd2dat_spt_pd),
      .dma_rd_cdt_lat_fifo_pop (dma_rd_cdt_lat_fifo_pop),
      .cdt_avail               (cdt_avail),
      .cdt_err                 (cdt_err),
      .sched_idle              (sched_idle)
   );

   always #5 nvdla_core_clk = ~nvdla_core_clk;

   // Record every accepted request and token.
   always @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rst) begin
         if (dma_rd_req_pvld && dma_rd_req_prdy) req_log.push_back(dma_rd_req_pd);
         if (cmd2dat_spt_pvld && cmd2dat_spt_prdy) spt_log.push_back(cmd2dat_spt_pd);
      end
   end

   function automatic logic [PW-1:0] mk(input int n, input logic [AW-1:0] a);
      return {SW'(n), a};
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   task automatic send_cmd(input int size, input logic [AW-1:0] addr);
      chk("cmd_prdy_idle", cmd_prdy, 1);
      cmd_pvld = 1'b1;
      cmd_pd   = {SW'(size), addr};
      @(negedge nvdla_core_clk);
      cmd_pvld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!cmd_prdy && n < 2000) begin
         @(negedge nvdla_core_clk);
         n++;
      end
      chk(tag, cmd_prdy, 1);
   endtask

   task automatic clear_logs();
      req_log.delete();
      spt_log.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      nvdla_core_rst          = 1'b1;
      cmd_pvld                = 1'b0;
      cmd_pd                  = '0;
      dma_rd_req_prdy         = 1'b0;
      cmd2dat_spt_prdy        = 1'b0;
      dma_rd_cdt_lat_fifo_pop = 1'b0;
      repeat (2) @(negedge nvdla_core_clk);

      // Reset state
      chk("rst_cmd_prdy", cmd_prdy, 1);
      chk("rst_req_pvld", dma_rd_req_pvld, 0);
      chk("rst_spt_pvld", cmd2dat_spt_pvld, 0);
      chk("rst_req_pd", dma_rd_req_pd, 0);
      chk("rst_spt_pd", cmd2dat_spt_pd, 0);
      chk("rst_credits", cdt_avail, 256);
      chk("rst_cdt_err", cdt_err, 0);
      chk("rst_idle", sched_idle, 1);
      nvdla_core_rst = 1'b0;
      @(negedge nvdla_core_clk);

      // Overflow: pop with all credits present
      dma_rd_cdt_lat_fifo_pop = 1'b1;
      @(negedge nvdla_core_clk);
      dma_rd_cdt_lat_fifo_pop = 1'b0;
      chk("ovf_credits", cdt_avail, 256);
      chk("ovf_err", cdt_err, 1);
      repeat (3) @(negedge nvdla_core_clk);
      chk("ovf_err_sticky", cdt_err, 1);
      nvdla_core_rst = 1'b1;
      @(negedge nvdla_core_clk);
      chk("ovf_err_cleared", cdt_err, 0);
      nvdla_core_rst = 1'b0;
      @(negedge nvdla_core_clk);

      // Single command, 40 atoms at 0x1000
      dma_rd_req_prdy  = 1'b1;
      cmd2dat_spt_prdy = 1'b1;
      clear_logs();
      send_cmd(39, 64'h1000);
      chk("t1_calc_no_req", dma_rd_req_pvld, 0);
      chk("t1_busy_prdy", cmd_prdy, 0);
      @(negedge nvdla_core_clk);
      chk("t1_first_req_pvld", dma_rd_req_pvld, 1);
      chk("t1_first_req_pd", dma_rd_req_pd, mk(15, 64'h1000));
      wait_done("t1_done");
      chk("t1_nreq", req_log.size(), 3);
      chk("t1_nspt", spt_log.size(), 3);
      if (req_log.size() == 3 && spt_log.size() == 3) begin
         chk("t1_req0", req_log[0], mk(15, 64'h1000));
         chk("t1_req1", req_log[1], mk(15, 64'h1200));
         chk("t1_req2", req_log[2], mk(7, 64'h1400));
         chk("t1_spt0", spt_log[0], 15);
         chk("t1_spt1", spt_log[1], 15);
         chk("t1_spt2", spt_log[2], 7);
      end
      chk("t1_credits", cdt_avail, 216);

      // Command straddling a 4 KB boundary
      clear_logs();
      send_cmd(15, 64'h1FC0);
      wait_done("b4k_done");
`ifdef NVDLA_SDP_MRDMA_4KB_SPLIT_EN
      chk("b4k_nreq", req_log.size(), 2);
      if (req_log.size() == 2 && spt_log.size() == 2) begin
         chk("b4k_req0", req_log[0], mk(1, 64'h1FC0));
         chk("b4k_req1", req_log[1], mk(13, 64'h2000));
         chk("b4k_spt0", spt_log[0], 1);
         chk("b4k_spt1", spt_log[1], 13);
      end
`else
      chk("b4k_nreq", req_log.size(), 1);
      if (req_log.size() == 1 && spt_log.size() == 1) begin
         chk("b4k_req0", req_log[0], mk(15, 64'h1FC0));
         chk("b4k_spt0", spt_log[0], 15);
      end
`endif
      chk("b4k_credits", cdt_avail, 200);

      // Split handshake: token held off while the request is accepted at once
      cmd2dat_spt_prdy = 1'b0;
      clear_logs();
      send_cmd(31, 64'h8000);
      @(negedge nvdla_core_clk);
      chk("sp_req_pvld", dma_rd_req_pvld, 1);
      chk("sp_spt_pvld", cmd2dat_spt_pvld, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge nvdla_core_clk);
         chk("sp_req_dropped", dma_rd_req_pvld, 0);
         chk("sp_spt_held", cmd2dat_spt_pvld, 1);
         chk("sp_spt_pd_stable", cmd2dat_spt_pd, 15);
      end
      cmd2dat_spt_prdy = 1'b1;
      @(negedge nvdla_core_clk);
      chk("sp_spt_retired", cmd2dat_spt_pvld, 0);
      chk("sp_calc_no_req", dma_rd_req_pvld, 0);
      @(negedge nvdla_core_clk);
      chk("sp_next_req_pvld", dma_rd_req_pvld, 1);
      chk("sp_next_req_pd", dma_rd_req_pd, mk(15, 64'h8200));
      wait_done("sp_done");
      chk("sp_nreq", req_log.size(), 2);
      chk("sp_nspt", spt_log.size(), 2);
      chk("sp_credits", cdt_avail, 168);

      // Drain every remaining credit
      clear_logs();
      send_cmd(167, 64'h10000);
      wait_done("drain_done");
      chk("drain_nreq", req_log.size(), 11);
      if (req_log.size() == 11) chk("drain_last", req_log[10], mk(7, 64'h11400));
      chk("drain_credits", cdt_avail, 0);

      // Credit stall, then grant netted with a pop
      clear_logs();
      send_cmd(15, 64'h3000);
      repeat (5) @(negedge nvdla_core_clk);
      chk("stall_no_req", dma_rd_req_pvld, 0);
      chk("stall_log_empty", req_log.size(), 0);
      dma_rd_cdt_lat_fifo_pop = 1'b1;
      repeat (15) @(negedge nvdla_core_clk);
      chk("stall_credits15", cdt_avail, 15);
      chk("stall_still_no_req", dma_rd_req_pvld, 0);
      @(negedge nvdla_core_clk);
      chk("stall_credits16", cdt_avail, 16);
      chk("stall_req_not_yet", dma_rd_req_pvld, 0);
      @(negedge nvdla_core_clk);
      dma_rd_cdt_lat_fifo_pop = 1'b0;
      chk("net_credits", cdt_avail, 1);
      chk("net_req_pvld", dma_rd_req_pvld, 1);
      chk("net_req_pd", dma_rd_req_pd, mk(15, 64'h3000));
      chk("net_cdt_err", cdt_err, 0);
      wait_done("stall_done");
      chk("stall_end_credits", cdt_avail, 1);

      // Reset while a command is stalled drops it and restores credits
      send_cmd(15, 64'h4000);
      repeat (2) @(negedge nvdla_core_clk);
      chk("mid_busy", cmd_prdy, 0);
      nvdla_core_rst = 1'b1;
      #1;
      chk("mid_rst_credits", cdt_avail, 256);
      chk("mid_rst_prdy", cmd_prdy, 1);
      chk("mid_rst_idle", sched_idle, 1);
      @(negedge nvdla_core_clk);
      nvdla_core_rst = 1'b0;
      @(negedge nvdla_core_clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
